// File: rtl/tour_cmd.sv
// ---------------------------------------------------------------------------
// tour_cmd
//   Sequences a solved knight's tour into motion commands. When idle, it
//   forwards the UART command path. On start_tour it walks the 24 stored
//   moves. For each move it issues a vertical command, waits for it to
//   complete, then issues a horizontal command and waits again.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start_tour     pulse: solver has a tour ready
//   move[7:0]      one-hot knight move at mv_indx (combinational read)
//   mv_indx[4:0]   index of the move currently being read (0..23)
//   cmd_UART[15:0] command from the UART path
//   cmd_rdy_UART   UART command valid
//   clr_cmd_rdy    pulse: downstream accepted the current command
//   send_resp      pulse: downstream finished the current command
//   cmd[15:0]      {opcode[15:12], heading[11:4], count[3:0]}
//   cmd_rdy        cmd valid
//   resp[7:0]      response byte back to the UART path
// ---------------------------------------------------------------------------
module tour_cmd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_INDX = 5'd23;

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    state_t      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;

    logic signed [2:0] x_off, y_off;
    logic [2:0]        x_mag, y_mag;
    logic [15:0]       vert_cmd, horz_cmd;

    // Lowest set bit wins; a zero move decodes to a zero offset.
    always_comb begin
        x_off = '0;
        y_off = '0;
        casez (move)
            8'b???????1: begin x_off = -3'sd1; y_off =  3'sd2; end
            8'b??????10: begin x_off =  3'sd1; y_off =  3'sd2; end
            8'b?????100: begin x_off = -3'sd2; y_off =  3'sd1; end
            8'b????1000: begin x_off = -3'sd2; y_off = -3'sd1; end
            8'b???10000: begin x_off = -3'sd1; y_off = -3'sd2; end
            8'b??100000: begin x_off =  3'sd1; y_off = -3'sd2; end
            8'b?1000000: begin x_off =  3'sd2; y_off =  3'sd1; end
            8'b10000000: begin x_off =  3'sd2; y_off = -3'sd1; end
            default:     begin x_off = '0;     y_off = '0;     end
        endcase
    end

    assign x_mag = x_off[2] ? 3'(-x_off) : 3'(x_off);
    assign y_mag = y_off[2] ? 3'(-y_off) : 3'(y_off);

    // Zero offset falls through to heading 8'h00 for both axes.
    assign vert_cmd = {4'h2, (y_off[2] ? 8'hFF : 8'h00), {1'b0, y_mag}};
    assign horz_cmd = {4'h3,
                       (x_off[2] ? 8'hBF : ((x_off != 3'sd0) ? 8'h3F : 8'h00)),
                       {1'b0, x_mag}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        cmd       = cmd_UART;
        cmd_rdy   = cmd_rdy_UART;
        resp      = 8'h5A;
        case (state_q)
            IDLE: begin
                resp = 8'hA5;
                if (start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = '0;
                end
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_V;
            end
            WAIT_V: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                if (mv_indx_q == LAST_INDX) resp = 8'hA5;
                if (send_resp) begin
                    if (mv_indx_q == LAST_INDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mv_indx = mv_indx_q;

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have parameters: none; all widths and encodings fixed by this document.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start_tour  input  1  one-cycle pulse from the tour solver, solution ready.
REQ-005 move  input  8  one-hot knight move read back from the solver at mv_indx, valid same cycle (combinational read).
REQ-006 mv_indx  output  5  index (0..23) of the move being read from the solver.
REQ-007 cmd_UART  input  16  command from the UART command path.
REQ-008 cmd_rdy_UART  input  1  UART command valid.
REQ-009 clr_cmd_rdy  input  1  downstream command processor accepted the current command (one-cycle pulse).
REQ-010 send_resp  input  1  downstream command processor finished executing the current command (one-cycle pulse).
REQ-011 cmd  output  16  command presented downstream: [15:12] opcode, [11:4] heading, [3:0] square count.
REQ-012 cmd_rdy  output  1  cmd valid.
REQ-013 resp  output  8  response byte returned to the UART path.

Function
REQ-014 SHALL implement FSM states IDLE, VERT, WAIT_V, HORZ, WAIT_H, with IDLE as the reset state.
REQ-015 In IDLE: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART (combinational pass-through, zero latency).
REQ-016 IDLE -> VERT on start_tour; mv_indx loads 0 on the same edge.
REQ-017 start_tour SHALL be ignored in every state other than IDLE.
REQ-018 VERT: cmd_rdy=1, cmd = vertical command for move; -> WAIT_V on clr_cmd_rdy.
REQ-019 WAIT_V: cmd_rdy=0, cmd holds the vertical command; -> HORZ on send_resp.
REQ-020 HORZ: cmd_rdy=1, cmd = horizontal command for move; -> WAIT_H on clr_cmd_rdy.
REQ-021 WAIT_H: cmd_rdy=0; on send_resp: if mv_indx==23 -> IDLE, else mv_indx increments by 1 -> VERT.
REQ-022 send_resp SHALL be ignored in VERT and HORZ; clr_cmd_rdy SHALL be ignored in WAIT_V and WAIT_H; both are ignored by the FSM in IDLE.
REQ-023 Vertical command: opcode 4'h2 (move); heading 8'h00 (north) if y offset > 0, 8'hFF (south) if < 0; count = |y offset|.
REQ-024 Horizontal command: opcode 4'h3 (move with fanfare); heading 8'h3F (east) if x offset > 0, 8'hBF (west) if < 0; count = |x offset|.
REQ-025 Move decode (x,y): bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,+1), bit7 (+2,-1).
REQ-026 Non-one-hot move: lowest set bit is decoded; move==0 yields count 0 and heading 8'h00 for both commands, and the FSM still sequences normally.
REQ-027 resp = 8'hA5 in IDLE and in WAIT_H when mv_indx==23; resp = 8'h5A in all other states.
REQ-028 mv_indx SHALL hold its value in IDLE after a tour (it is not cleared until the next start_tour).
REQ-029 A complete tour SHALL issue exactly 48 commands: for each index, the vertical command then the horizontal command.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE and mv_indx=0.
REQ-031 During reset: cmd_rdy = cmd_rdy_UART, cmd = cmd_UART, resp = 8'hA5.
REQ-032 Reset asserted mid-tour SHALL abort the tour with no further tour commands issued; after release the block stays in IDLE until the next start_tour.

Verification
REQ-033 Reset, cmd_UART=16'h1234, cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, resp=8'hA5, mv_indx=0.
REQ-034 start_tour, move=8'h02 -> cmd=16'h2002, cmd_rdy=1; after clr_cmd_rdy then send_resp -> cmd=16'h33F1, cmd_rdy=1, resp=8'h5A.
REQ-035 move=8'h08 at index 5 -> vertical cmd 16'h2FF1, horizontal cmd 16'h3BF2; mv_indx advances to 6 after the second send_resp.
REQ-036 Full 24-move tour with scripted clr_cmd_rdy/send_resp -> 48 cmd_rdy assertions, resp=8'hA5 in the final WAIT_H, return to IDLE, mv_indx=23.
REQ-037 start_tour pulse in WAIT_V, plus clr_cmd_rdy and send_resp asserted together in VERT -> no restart; VERT -> WAIT_V only, send_resp ignored.
REQ-038 rst_n low in HORZ at mv_indx=10 -> immediate IDLE, mv_indx=0, cmd follows cmd_UART.
